// File: rtl/i2c_codec_responder.sv
// I2C write-only register responder for an audio codec style control port.
// Accepts {addr,W} + {reg[6:0],data[8]} + {data[7:0]}, ACKs each byte and
// commits the 9-bit value into a small register file once the frame completes.
module i2c_codec_responder #(
  parameter logic [6:0] DEV_ADDR = 7'b0011010,
  parameter int         NREG     = 16
) (
  input  logic       CLOCK_50,
  input  logic       rst,
  input  logic       SDCLK,
  inout  wire        SDAT,
  output logic       wr_valid,
  output logic [6:0] wr_reg,
  output logic [8:0] wr_data,
  input  logic [3:0] rd_sel,
  output logic [8:0] rd_data,
  output logic       busy,
  output logic [7:0] frame_cnt,
  output logic [2:0] err
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ADDR   = 3'd1;
  localparam logic [2:0] S_ACK_A  = 3'd2;
  localparam logic [2:0] S_BYTE1  = 3'd3;
  localparam logic [2:0] S_ACK_1  = 3'd4;
  localparam logic [2:0] S_BYTE2  = 3'd5;
  localparam logic [2:0] S_ACK_2  = 3'd6;
  localparam logic [2:0] S_IGNORE = 3'd7;

  // [0] first flop, [1] synchronized value, [2] previous synchronized value
  logic [2:0] scl_q, sda_q;
  logic [2:0] state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] shift_q, shift_d;
  logic       ack_on_q, ack_on_d;
  logic [6:0] reg_idx_q, reg_idx_d;
  logic       data_hi_q, data_hi_d;
  logic [7:0] data_lo_q, data_lo_d;
  logic       commit_q, commit_d;
  logic [2:0] err_set;
  logic       wr_valid_q;
  logic [6:0] wr_reg_q;
  logic [8:0] wr_data_q;
  logic [8:0] rd_data_q, rd_mux;
  logic [7:0] frame_cnt_q;
  logic [2:0] err_q;
  logic [8:0] regs_w [NREG];

  wire start_w  = scl_q[1] & scl_q[2] & sda_q[2] & ~sda_q[1];
  wire stop_w   = scl_q[1] & scl_q[2] & ~sda_q[2] & sda_q[1];
  wire rise_w   = scl_q[1] & ~scl_q[2];
  wire fall_w   = ~scl_q[1] & scl_q[2];
  wire in_frame = (state_q != S_IDLE) && (state_q != S_IGNORE);
  wire [7:0] byte_w = {shift_q, sda_q[1]};

  // Codec reset (reg 15) wins over an ordinary write; out-of-range indices only flag.
  wire clr_all = commit_q && (reg_idx_q == 7'd15);
  wire reg_ok  = int'(reg_idx_q) < NREG;
  wire wr_en   = commit_q && !clr_all && reg_ok;
  wire bad_idx = commit_q && !clr_all && !reg_ok;

  // Bus inputs pass a 2-flop synchronizer plus one history flop for edge detect
  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      scl_q <= 3'b111;
      sda_q <= 3'b111;
    end else begin
      scl_q <= {scl_q[1:0], SDCLK};
      sda_q <= {sda_q[1:0], SDAT};
    end
  end

  // Frame sequencer: START/STOP override bit sampling; ACK spans one full clock
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    ack_on_d  = ack_on_q;
    reg_idx_d = reg_idx_q;
    data_hi_d = data_hi_q;
    data_lo_d = data_lo_q;
    commit_d  = 1'b0;
    err_set   = 3'b000;
    if (start_w) begin
      state_d   = S_ADDR;
      bit_cnt_d = 3'd0;
      shift_d   = 7'd0;
      ack_on_d  = 1'b0;
      err_set[1] = in_frame;
    end else if (stop_w) begin
      state_d   = S_IDLE;
      ack_on_d  = 1'b0;
      err_set[1] = in_frame;
    end else begin
      case (state_q)
        S_ADDR, S_BYTE1, S_BYTE2: begin
          if (rise_w) begin
            shift_d   = byte_w[6:0];
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (state_q == S_ADDR) begin
                if (byte_w[7:1] == DEV_ADDR && !byte_w[0]) begin
                  state_d = S_ACK_A;
                end else begin
                  state_d    = S_IGNORE;
                  err_set[0] = 1'b1;
                end
              end else if (state_q == S_BYTE1) begin
                reg_idx_d = byte_w[7:1];
                data_hi_d = byte_w[0];
                state_d   = S_ACK_1;
              end else begin
                data_lo_d = byte_w;
                state_d   = S_ACK_2;
              end
            end
          end
        end
        S_ACK_A, S_ACK_1, S_ACK_2: begin
          if (fall_w) begin
            if (!ack_on_q) begin
              ack_on_d = 1'b1;
            end else begin
              ack_on_d  = 1'b0;
              bit_cnt_d = 3'd0;
              shift_d   = 7'd0;
              if (state_q == S_ACK_A) begin
                state_d = S_BYTE1;
              end else if (state_q == S_ACK_1) begin
                state_d = S_BYTE2;
              end else begin
                state_d  = S_IGNORE;
                commit_d = 1'b1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Sequencer state, commit outputs and sticky error flags
  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 7'd0;
      ack_on_q    <= 1'b0;
      reg_idx_q   <= 7'd0;
      data_hi_q   <= 1'b0;
      data_lo_q   <= 8'd0;
      commit_q    <= 1'b0;
      wr_valid_q  <= 1'b0;
      wr_reg_q    <= 7'd0;
      wr_data_q   <= 9'd0;
      frame_cnt_q <= 8'd0;
      err_q       <= 3'b000;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      ack_on_q   <= ack_on_d;
      reg_idx_q  <= reg_idx_d;
      data_hi_q  <= data_hi_d;
      data_lo_q  <= data_lo_d;
      commit_q   <= commit_d;
      wr_valid_q <= commit_q;
      err_q      <= err_q | err_set | {bad_idx, 2'b00};
      if (commit_q) begin
        wr_reg_q    <= reg_idx_q;
        wr_data_q   <= {data_hi_q, data_lo_q};
        frame_cnt_q <= frame_cnt_q + 8'd1;
      end
    end
  end

  // One flop bank per register entry; flops rather than RAM because of the bulk clear
  for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
    logic [8:0] entry_q;
    always_ff @(posedge CLOCK_50) begin
      if (rst || clr_all) begin
        entry_q <= 9'd0;
      end else if (wr_en && reg_idx_q == 7'(gi)) begin
        entry_q <= {data_hi_q, data_lo_q};
      end
    end
    assign regs_w[gi] = entry_q;
  end

  // Read-select mux; unmapped selects read as zero
  always_comb begin
    rd_mux = 9'd0;
    for (int i = 0; i < NREG; i++) begin
      if (int'(rd_sel) == i) rd_mux = regs_w[i];
    end
  end

  // Registered read port
  always_ff @(posedge CLOCK_50) begin
    if (rst) rd_data_q <= 9'd0;
    else     rd_data_q <= rd_mux;
  end

  assign SDAT      = ack_on_q ? 1'b0 : 1'bz;
  assign wr_valid  = wr_valid_q;
  assign wr_reg    = wr_reg_q;
  assign wr_data   = wr_data_q;
  assign rd_data   = rd_data_q;
  assign busy      = (state_q != S_IDLE);
  assign frame_cnt = frame_cnt_q;
  assign err       = err_q;

endmodule

// File: tb/tb_i2c_codec_responder.sv
// Bench for i2c_codec_responder: bit-banged I2C initiator, reference register
// model, and a scoreboard monitor that checks every wr_valid pulse.
module tb_i2c_codec_responder;
  localparam logic [6:0] DEV = 7'h1A;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl = 1'b1;
  logic       m_low = 1'b0;
  logic [3:0] rd_sel = 4'd0;
  wire        sda_bus;
  logic       wr_valid, busy;
  logic [6:0] wr_reg;
  logic [8:0] wr_data, rd_data;
  logic [7:0] frame_cnt;
  logic [2:0] err;

  pullup (sda_bus);
  assign sda_bus = m_low ? 1'b0 : 1'bz;

  i2c_codec_responder dut (
    .CLOCK_50(clk), .rst(rst), .SDCLK(scl), .SDAT(sda_bus),
    .wr_valid(wr_valid), .wr_reg(wr_reg), .wr_data(wr_data),
    .rd_sel(rd_sel), .rd_data(rd_data), .busy(busy),
    .frame_cnt(frame_cnt), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int stray  = 0;

  // Reference model: register contents, commit count, sticky error flags
  logic [8:0]  m_regs [16];
  int          m_cnt = 0;
  logic [2:0]  m_err = 3'b000;
  logic [23:0] exp_q [$];   // {reg, data, frame_cnt} per expected commit

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Scoreboard monitor: every wr_valid cycle must match the next expected commit
  always @(negedge clk) begin
    if (!rst && wr_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_wr_valid", 32'd1, 32'd0);
      end else begin
        logic [23:0] e;
        e = exp_q.pop_front();
        check("wr_reg", 32'(wr_reg), 32'(e[23:17]));
        check("wr_data", 32'(wr_data), 32'(e[16:8]));
        check("frame_cnt_at_commit", 32'(frame_cnt), 32'(e[7:0]));
        $display("commit reg=%0d data=%03h cnt=%0d", wr_reg, wr_data, frame_cnt);
      end
    end
  end

  task automatic m_start();
    m_low = 1'b0; cyc(4);
    scl = 1'b1;   cyc(3);
    m_low = 1'b1; cyc(3);
    scl = 1'b0;   cyc(1);
  endtask

  task automatic m_stop();
    m_low = 1'b1; cyc(4);
    scl = 1'b1;   cyc(3);
    m_low = 1'b0; cyc(4);
  endtask

  task automatic m_bit(input bit b, output bit seen);
    m_low = !b; cyc(4);
    scl = 1'b1; cyc(1);
    seen = sda_bus; cyc(1);
    scl = 1'b0; cyc(1);
  endtask

  task automatic m_byte(input logic [7:0] v, output bit acked);
    bit s;
    for (int i = 7; i >= 0; i--) begin
      m_bit(v[i], s);
      if (v[i] && !s) stray++;
    end
    m_bit(1'b1, s);
    acked = !s;
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = 9'd0;
    m_cnt = 0;
    m_err = 3'b000;
  endfunction

  // mode 0: full frame, 1: STOP after BYTE1 ACK, 2: extra trailing byte
  task automatic frame(input logic [6:0] a, input bit rw, input logic [6:0] r,
                       input logic [8:0] d, input int mode);
    bit exp_a, ok;
    exp_a = (a == DEV) && !rw;
    if (!exp_a) begin
      m_err[0] = 1'b1;
    end else if (mode == 1) begin
      m_err[1] = 1'b1;
    end else begin
      m_cnt = (m_cnt + 1) % 256;
      if (r == 7'd15) for (int i = 0; i < 16; i++) m_regs[i] = 9'd0;
      else if (r < 7'd16) m_regs[r[3:0]] = d;
      else m_err[2] = 1'b1;
      exp_q.push_back({r, d, 8'(m_cnt)});
    end
    stray = 0;
    m_start();
    check("busy_in_frame", 32'(busy), 32'd1);
    m_byte({a, rw}, ok);
    check("ack_addr", 32'(ok), 32'(exp_a));
    m_byte({r, d[8]}, ok);
    check("ack_byte1", 32'(ok), 32'(exp_a));
    if (mode != 1) begin
      m_byte(d[7:0], ok);
      check("ack_byte2", 32'(ok), 32'(exp_a));
    end
    if (mode == 2) begin
      m_byte(8'($urandom), ok);
      check("ack_extra", 32'(ok), 32'd0);
    end
    m_stop();
    check("stray_drive", 32'(stray), 32'd0);
    check("busy_after_stop", 32'(busy), 32'd0);
    check("err", 32'(err), 32'(m_err));
    check("frame_cnt", 32'(frame_cnt), 32'(m_cnt % 256));
    rd_sel = 4'($urandom);
    cyc(2);
    check("rd_data", 32'(rd_data), 32'(m_regs[rd_sel]));
    $display("frame addr=%02h rw=%0d reg=%0d data=%03h mode=%0d", a, rw, r, d, mode);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wr_valid"}, 32'(wr_valid), 32'd0);
    check({tag, "_wr_reg"}, 32'(wr_reg), 32'd0);
    check({tag, "_wr_data"}, 32'(wr_data), 32'd0);
    check({tag, "_rd_data"}, 32'(rd_data), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_frame_cnt"}, 32'(frame_cnt), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_sdat"}, 32'(sda_bus), 32'd1);
  endtask

  initial begin
    repeat (95000) @(posedge clk);
    $display("FAIL watchdog cycle budget expired");
    $fatal(1);
  end

  initial begin
    bit ok, s, wrapped;
    model_reset();
    rd_sel = 4'd6;
    cyc(4);
    check_reset_outputs("reset");
    rst = 1'b0;
    cyc(4);

    // Directed frames
    frame(DEV, 1'b0, 7'd6, 9'h010, 0);
    rd_sel = 4'd6; cyc(2);
    check("rd_reg6", 32'(rd_data), 32'h010);
    frame(7'h1B, 1'b0, 7'd3, 9'h055, 0);
    frame(DEV, 1'b1, 7'd6, 9'h1AA, 0);
    rd_sel = 4'd6; cyc(2);
    check("rd_reg6_after_read_nack", 32'(rd_data), 32'h010);
    frame(DEV, 1'b0, 7'd4, 9'h1FF, 0);
    frame(DEV, 1'b0, 7'd15, 9'h000, 0);
    rd_sel = 4'd4; cyc(2);
    check("rd_reg4_after_clear", 32'(rd_data), 32'h000);
    frame(DEV, 1'b0, 7'd2, 9'h123, 1);
    frame(DEV, 1'b0, 7'd17, 9'h0F0, 0);

    // Repeated START in the middle of BYTE1 aborts that frame
    m_start();
    m_byte({DEV, 1'b0}, ok);
    for (int i = 0; i < 3; i++) m_bit(1'b1, s);
    m_err[1] = 1'b1;
    frame(DEV, 1'b0, 7'd9, 9'h0AB, 0);

    // Randomized frames
    for (int k = 0; k < 40; k++) begin
      logic [6:0] a, r;
      bit rw;
      int mode;
      a    = ($urandom_range(0, 6) == 0) ? 7'($urandom) : DEV;
      rw   = ($urandom_range(0, 9) == 0);
      r    = 7'($urandom_range(0, 19));
      mode = ($urandom_range(0, 9) == 0) ? 1 : (($urandom_range(0, 5) == 0) ? 2 : 0);
      frame(a, rw, r, 9'($urandom), mode);
    end

    // Valid frames until the commit counter wraps to zero
    wrapped = 1'b0;
    for (int k = 0; k < 300 && !wrapped; k++) begin
      frame(DEV, 1'b0, 7'($urandom_range(0, 14)), 9'($urandom), 0);
      if (m_cnt == 0) wrapped = 1'b1;
    end
    check("wrap_reached", 32'(wrapped), 32'd1);
    check("frame_cnt_wrapped", 32'(frame_cnt), 32'd0);

    // Reset in the middle of BYTE2
    m_start();
    m_byte({DEV, 1'b0}, ok);
    m_byte({7'd5, 1'b1}, ok);
    for (int i = 0; i < 4; i++) m_bit(1'b1, s);
    rst = 1'b1;
    m_low = 1'b0;
    cyc(1);
    check_reset_outputs("midframe_rst");
    model_reset();
    scl = 1'b1;
    cyc(3);
    rst = 1'b0;
    cyc(3);
    frame(DEV, 1'b0, 7'd5, 9'h1C3, 0);
    rd_sel = 4'd5; cyc(2);
    check("rd_reg5_after_rst", 32'(rd_data), 32'h1C3);

    cyc(4);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
